// File: rtl/alu_seq_pkg.sv
// Shared op codes and controller state encoding for the ALU sequencer.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/result handshake bundle between the driver (master) and the sequencer (slave).
interface alu_sequencer_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic         busy;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_carry, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_carry, busy
    );
endinterface

// File: rtl/alu_core.sv
// Combinational single-cycle ALU for every op except MUL; MUL yields zero here.
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         carry
);
    localparam int SW = $clog2(W);

    logic [W:0]    sum;
    logic [W:0]    diff;
    logic [SW-1:0] shamt;
    logic          lt;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    assign shamt = b[SW-1:0];
    assign lt    = $signed(a) < $signed(b);

    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[W-1:0];
                carry  = sum[W];
            end
            OP_SUB: begin
                result = diff[W-1:0];
                carry  = diff[W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(W-1){1'b0}}, lt};
            OP_SLL:  result = a << shamt;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Controller: accepts one request, runs it (single cycle or W-step shift-add MUL),
// and holds the result until the consumer takes it.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_sequencer_if.slave bus
);
    localparam int             CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t        state;
    logic [2:0]    op_r;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  acc;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc_next;
    logic [W-1:0]  core_result;
    logic          core_carry;
    logic          accept;

    assign accept   = bus.in_valid && (state == IDLE);
    assign acc_next = mplier[0] ? acc + mcand : acc;

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);

    alu_core #(.W(W)) u_core (
        .op     (op_r),
        .a      (a_r),
        .b      (b_r),
        .result (core_result),
        .carry  (core_carry)
    );

    // NOTE: operand and iterator data registers have no reset; each is loaded on accept before it is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_r <= bus.in_op;
            a_r  <= bus.in_a;
            b_r  <= bus.in_b;
        end
        if (state == MUL) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end else if (accept) begin
            mcand  <= bus.in_a;
            mplier <= bus.in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_carry  <= 1'b0;
            cnt            <= '0;
            acc            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= (bus.in_op == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    bus.out_result <= core_result;
                    bus.out_carry  <= core_carry;
                    bus.out_valid  <= 1'b1;
                    state          <= DONE;
                end
                MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    // The last step's sum goes straight to the result register.
                    if (cnt == CNT_LAST) begin
                        bus.out_result <= acc_next;
                        bus.out_carry  <= 1'b0;
                        bus.out_valid  <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer with a queue scoreboard and an independent output monitor.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] result;
        logic         carry;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    alu_sequencer_if #(.W(W)) bus ();

    alu_sequencer #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compares each newly presented result against the oldest expectation.
    logic seen = 1'b0;
    exp_t mon_e;
    int   mon_idx = 0;
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && !seen) begin
            seen = 1'b1;
            if (sb_q.size() == 0) begin
                check($sformatf("unexpected_output_%0d", mon_idx), 64'(bus.out_result), 64'hDEAD);
            end else begin
                mon_e = sb_q.pop_front();
                check($sformatf("result_%0d", mon_idx), 64'(bus.out_result), 64'(mon_e.result));
                check($sformatf("carry_%0d", mon_idx), 64'(bus.out_carry), 64'(mon_e.carry));
            end
            mon_idx++;
        end else if (bus.out_valid !== 1'b1) begin
            seen = 1'b0;
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_in_time", 64'(n < 200), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output bit hs_ok);
        lat   = 0;
        hs_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) hs_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("in_ready_after_consume", 64'(bus.in_ready), 64'd1);
        check("busy_after_consume", 64'(bus.busy), 64'd0);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ec, input int exp_lat);
        int lat;
        bit ok;
        sb_q.push_back('{result: er, carry: ec});
        send(op, a, b);
        wait_valid(lat, ok);
        check($sformatf("latency_op%0d", op), 64'(lat), 64'(exp_lat));
        check($sformatf("stall_flags_op%0d", op), 64'(ok), 64'd1);
        consume();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held;
        int           lat;
        bit           ok;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = OP_ADD;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_result", 64'(bus.out_result), 64'd0);
        check("reset_out_carry", 64'(bus.out_carry), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_busy", 64'(bus.busy), 64'd0);

        run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 1'b1, 1);
        run_op(OP_SUB, 32'h3,         32'h5,         32'hFFFF_FFFE, 1'b0, 1);
        run_op(OP_SLT, 32'hFFFF_FFFF, 32'h1,         32'h0000_0001, 1'b0, 1);
        run_op(OP_SUB, 32'h5,         32'h3,         32'h0000_0002, 1'b1, 1);
        run_op(OP_SLT, 32'h1,         32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1);
        run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1);
        run_op(OP_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 1);
        run_op(OP_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1'b0, 1);
        run_op(OP_SLL, 32'h1,         32'd33,        32'h0000_0002, 1'b0, 1);
        run_op(OP_MUL, 32'h0001_0003, 32'h5,         32'h0005_000F, 1'b0, 32);
        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32);

        // Backpressure: result held while new requests are offered and ignored.
        sb_q.push_back('{result: 32'h30, carry: 1'b0});
        send(OP_ADD, 32'h10, 32'h20);
        wait_valid(lat, ok);
        check("bp_latency", 64'(lat), 64'd1);
        held         = bus.out_result;
        bus.in_valid = 1'b1;
        bus.in_op    = OP_SUB;
        bus.in_a     = 32'h1234;
        bus.in_b     = 32'h0042;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_result_hold_%0d", i), 64'(bus.out_result), 64'(held));
            check($sformatf("bp_out_valid_%0d", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp_in_ready_%0d", i), 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        consume();

        // Reset ten cycles into a MUL aborts it; no result is expected from it.
        send(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("mid_mul_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_out_result", 64'(bus.out_result), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_busy", 64'(bus.busy), 64'd0);

        run_op(OP_ADD, 32'h2, 32'h2, 32'h0000_0004, 1'b0, 1);

        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        check("outputs_seen", 64'(mon_idx), 64'd13);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
